// File: rtl/sdram_arb_pkg.sv
// Shared constants for the two-port SDRAM arbiter: FSM encoding, op bit indices, default widths.
package sdram_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALL = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int WR = 1;
    localparam int RD = 0;

    localparam int DEF_AW = 24;
    localparam int DEF_DW = 64;

    // A request with both bits set is treated as a Write; the Read half is dropped.
    function automatic logic [1:0] op_of(input logic [1:0] call);
        return call[WR] ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sdram_arbmod_if.sv
// Bundle of both requester ports plus the SDRAM base-module call/done port.
interface sdram_arbmod_if
    import sdram_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) ();

    logic [1:0]    iCallA;
    logic [1:0]    oDoneA;
    logic [AW-1:0] iAddrA;
    logic [DW-1:0] iDataA;
    logic [DW-1:0] oDataA;

    logic [1:0]    iCallB;
    logic [1:0]    oDoneB;
    logic [AW-1:0] iAddrB;
    logic [DW-1:0] iDataB;
    logic [DW-1:0] oDataB;

    logic [1:0]    oCall;
    logic [1:0]    iDone;
    logic [AW-1:0] oAddr;
    logic [DW-1:0] oData;
    logic [DW-1:0] iData;
    logic          oBusy;
    logic          oGrant;

    modport slave (
        input  iCallA, iAddrA, iDataA,
        output oDoneA, oDataA,
        input  iCallB, iAddrB, iDataB,
        output oDoneB, oDataB,
        output oCall, oAddr, oData, oBusy, oGrant,
        input  iDone, iData
    );

    modport master (
        output iCallA, iAddrA, iDataA,
        input  oDoneA, oDataA,
        output iCallB, iAddrB, iDataB,
        input  oDoneB, oDataB,
        input  oCall, oAddr, oData, oBusy, oGrant,
        output iDone, iData
    );

endinterface

// File: rtl/sdram_rrpick.sv
// Combinational two-way picker: round-robin on the last winner, or fixed priority to A.
module sdram_rrpick #(
    parameter bit RR_EN = 1'b1
) (
    input  logic reqA,
    input  logic reqB,
    input  logic last,
    output logic gnt_valid,
    output logic gnt_sel
);

    // Contention goes to whichever port did not win last time (or always A in fixed mode).
    always_comb begin
        gnt_valid = reqA | reqB;
        gnt_sel   = 1'b0;
        if (reqA && reqB) begin
            gnt_sel = RR_EN ? ~last : 1'b0;
        end else if (reqB) begin
            gnt_sel = 1'b1;
        end
    end

endmodule

// File: rtl/sdram_arbmod.sv
// Two-port arbiter/sequencer in front of the SDRAM base module call/done interface.
// One transaction at a time: grant in IDLE, hold the call in CALL, one quiet cycle in DONE.
module sdram_arbmod
    import sdram_arb_pkg::*;
#(
    parameter bit RR_EN = 1'b1,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW
) (
    input  logic          CLOCK,
    input  logic          RESET,
    sdram_arbmod_if.slave bus
);

    logic [1:0]    state;
    logic          last;
    logic          gnt_valid;
    logic          gnt_sel;
    logic [1:0]    pick_call;
    logic [AW-1:0] pick_addr;
    logic [DW-1:0] pick_data;
    logic          op_done;

    sdram_rrpick #(.RR_EN(RR_EN)) u_pick (
        .reqA      (|bus.iCallA),
        .reqB      (|bus.iCallB),
        .last      (last),
        .gnt_valid (gnt_valid),
        .gnt_sel   (gnt_sel)
    );

    always_comb begin
        pick_call = bus.iCallA;
        pick_addr = bus.iAddrA;
        pick_data = bus.iDataA;
        if (gnt_sel) begin
            pick_call = bus.iCallB;
            pick_addr = bus.iAddrB;
            pick_data = bus.iDataB;
        end
    end

    // oCall carries the one-hot op while in CALL, so only the matching done bit completes it.
    assign op_done = |(bus.iDone & bus.oCall);

    // last starts at B so the first contended grant goes to A.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state      <= ST_IDLE;
            last       <= 1'b1;
            bus.oCall  <= 2'b00;
            bus.oAddr  <= '0;
            bus.oData  <= '0;
            bus.oBusy  <= 1'b0;
            bus.oGrant <= 1'b0;
            bus.oDoneA <= 2'b00;
            bus.oDoneB <= 2'b00;
            bus.oDataA <= '0;
            bus.oDataB <= '0;
        end else begin
            bus.oDoneA <= 2'b00;
            bus.oDoneB <= 2'b00;
            case (state)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        bus.oCall  <= op_of(pick_call);
                        bus.oAddr  <= pick_addr;
                        bus.oData  <= pick_data;
                        bus.oGrant <= gnt_sel;
                        bus.oBusy  <= 1'b1;
                        state      <= ST_CALL;
                    end
                end
                ST_CALL: begin
                    if (op_done) begin
                        if (bus.oGrant) begin
                            bus.oDoneB <= bus.oCall;
                            if (bus.oCall[RD]) bus.oDataB <= bus.iData;
                        end else begin
                            bus.oDoneA <= bus.oCall;
                            if (bus.oCall[RD]) bus.oDataA <= bus.iData;
                        end
                        bus.oCall <= 2'b00;
                        bus.oBusy <= 1'b0;
                        last      <= bus.oGrant;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbmod.sv
// Randomised self-checking bench for sdram_arbmod against a transaction-level arbitration/memory model.
module tb_sdram_arbmod;

    localparam int AW = 24;
    localparam int DW = 64;

    logic CLOCK = 1'b0;
    logic RESET = 1'b0;
    always #5 CLOCK = ~CLOCK;

    logic [1:0]    call_a, call_b, i_done;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] wdata_a, wdata_b, i_data;
    logic          use_fp;

    sdram_arbmod_if #(.AW(AW), .DW(DW)) bus_rr ();
    sdram_arbmod_if #(.AW(AW), .DW(DW)) bus_fp ();

    sdram_arbmod #(.RR_EN(1'b1), .AW(AW), .DW(DW)) dut_rr (.CLOCK(CLOCK), .RESET(RESET), .bus(bus_rr.slave));
    sdram_arbmod #(.RR_EN(1'b0), .AW(AW), .DW(DW)) dut_fp (.CLOCK(CLOCK), .RESET(RESET), .bus(bus_fp.slave));

    assign bus_rr.iCallA = call_a;  assign bus_fp.iCallA = call_a;
    assign bus_rr.iAddrA = addr_a;  assign bus_fp.iAddrA = addr_a;
    assign bus_rr.iDataA = wdata_a; assign bus_fp.iDataA = wdata_a;
    assign bus_rr.iCallB = call_b;  assign bus_fp.iCallB = call_b;
    assign bus_rr.iAddrB = addr_b;  assign bus_fp.iAddrB = addr_b;
    assign bus_rr.iDataB = wdata_b; assign bus_fp.iDataB = wdata_b;
    assign bus_rr.iDone  = i_done;  assign bus_fp.iDone  = i_done;
    assign bus_rr.iData  = i_data;  assign bus_fp.iData  = i_data;

    logic [1:0]    o_call, o_done_a, o_done_b;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_wdata, o_data_a, o_data_b;
    logic          o_busy, o_grant;

    // Observed outputs come from whichever arbiter variant the current test exercises.
    always_comb begin
        o_call = bus_rr.oCall;   o_done_a = bus_rr.oDoneA; o_done_b = bus_rr.oDoneB;
        o_addr = bus_rr.oAddr;   o_wdata  = bus_rr.oData;  o_data_a = bus_rr.oDataA;
        o_data_b = bus_rr.oDataB; o_busy  = bus_rr.oBusy;  o_grant  = bus_rr.oGrant;
        if (use_fp) begin
            o_call = bus_fp.oCall;   o_done_a = bus_fp.oDoneA; o_done_b = bus_fp.oDoneB;
            o_addr = bus_fp.oAddr;   o_wdata  = bus_fp.oData;  o_data_a = bus_fp.oDataA;
            o_data_b = bus_fp.oDataB; o_busy  = bus_fp.oBusy;  o_grant  = bus_fp.oGrant;
        end
    end

    int tests_run = 0;
    int tests_failed = 0;

    bit          model_last;
    logic [63:0] exp_data_a, exp_data_b;
    logic [63:0] mem [logic [23:0]];

    function automatic logic [63:0] mem_read(input logic [23:0] a);
        return mem.exists(a) ? mem[a] : {40'hA5A5A5A5A5, a};
    endfunction

    function automatic bit model_pick(input bit pa, input bit pb, input bit rr, input bit last_b);
        if (pa && pb) return rr ? !last_b : 1'b0;
        return pb;
    endfunction

    function automatic logic [1:0] model_op(input logic [1:0] c);
        return c[1] ? 2'b10 : 2'b01;
    endfunction

    int            wait_cycles, low_after;
    logic          timed_out, held_ok;
    logic [1:0]    seen_call, done_a1, done_b1, done_a2, done_b2, call_after;
    logic [AW-1:0] seen_addr;
    logic [DW-1:0] seen_wdata, data_a_after, data_b_after;
    logic          seen_grant, seen_busy, busy_after;

    // Acts as requester driver plus SDRAM responder for one transaction, recording what it saw.
    task automatic run_txn(input int lat, input bit bad_done, input bit drop_early, input bit drop_after);
        logic [63:0] rd_value;
        timed_out = 1'b0; held_ok = 1'b1; wait_cycles = 0;
        do begin @(negedge CLOCK); wait_cycles++; end while (o_call == 2'b00 && wait_cycles < 20);
        if (o_call == 2'b00) begin timed_out = 1'b1; return; end
        seen_call = o_call; seen_addr = o_addr; seen_wdata = o_wdata; seen_grant = o_grant; seen_busy = o_busy;
        if (drop_early) begin if (seen_grant) call_b = 2'b00; else call_a = 2'b00; end
        repeat (lat) begin
            @(negedge CLOCK);
            if (o_call !== seen_call || o_addr !== seen_addr || o_wdata !== seen_wdata || o_busy !== 1'b1) held_ok = 1'b0;
        end
        if (bad_done) begin
            i_done = ~seen_call;
            @(negedge CLOCK);
            i_done = 2'b00;
            if (o_call !== seen_call) held_ok = 1'b0;
        end
        rd_value = mem_read(seen_addr);
        i_done = seen_call;
        i_data = seen_call[0] ? rd_value : {$urandom, $urandom};
        if (seen_call[1]) mem[seen_addr] = seen_wdata;
        @(negedge CLOCK);
        i_done = 2'b00; i_data = {$urandom, $urandom};
        done_a1 = o_done_a; done_b1 = o_done_b; call_after = o_call; busy_after = o_busy;
        data_a_after = o_data_a; data_b_after = o_data_b;
        low_after = (o_call == 2'b00) ? 1 : 0;
        if (drop_after) begin if (seen_grant) call_b = 2'b00; else call_a = 2'b00; end
        @(negedge CLOCK);
        done_a2 = o_done_a; done_b2 = o_done_b;
        if (o_call == 2'b00) low_after++;
    endtask

    task automatic reset_both();
        @(negedge CLOCK);
        RESET = 1'b0; call_a = 2'b00; call_b = 2'b00; i_done = 2'b00;
        @(negedge CLOCK);
        RESET = 1'b1;
        model_last = 1'b1; exp_data_a = '0; exp_data_b = '0;
    endtask

    task automatic test_reset();
        @(negedge CLOCK);
        tests_run++; if (o_call !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_call: got %b expected 00", o_call); end
        tests_run++; if ({o_done_a, o_done_b} !== 4'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %b expected 0000", {o_done_a, o_done_b}); end
        tests_run++; if ({o_addr, o_wdata} !== '0) begin tests_failed++; $display("[TB] FAIL reset_addr_data: got %h/%h expected 0", o_addr, o_wdata); end
        tests_run++; if ({o_data_a, o_data_b} !== '0) begin tests_failed++; $display("[TB] FAIL reset_rdata: got %h/%h expected 0", o_data_a, o_data_b); end
        tests_run++; if ({o_busy, o_grant} !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_busy_grant: got %b expected 00", {o_busy, o_grant}); end
        RESET = 1'b1;
        model_last = 1'b1; exp_data_a = '0; exp_data_b = '0;
    endtask

    task automatic test_write_a();
        call_a = 2'b10; addr_a = 24'h000100; wdata_a = 64'h1122334455667788;
        run_txn(2, 1'b0, 1'b0, 1'b1);
        model_last = 1'b0;
        tests_run++; if (timed_out || wait_cycles != 1) begin tests_failed++; $display("[TB] FAIL wra_latency: got %0d cycles (timeout %b) expected 1", wait_cycles, timed_out); end
        tests_run++; if ({seen_call, seen_grant, seen_busy} !== 4'b1001) begin tests_failed++; $display("[TB] FAIL wra_call: got call %b grant %b busy %b expected 10/0/1", seen_call, seen_grant, seen_busy); end
        tests_run++; if (seen_addr !== 24'h000100 || seen_wdata !== 64'h1122334455667788) begin tests_failed++; $display("[TB] FAIL wra_addr_data: got %h/%h expected 000100/1122334455667788", seen_addr, seen_wdata); end
        tests_run++; if (!held_ok) begin tests_failed++; $display("[TB] FAIL wra_hold: got unstable call/addr/data expected stable"); end
        tests_run++; if (done_a1 !== 2'b10 || done_b1 !== 2'b00) begin tests_failed++; $display("[TB] FAIL wra_done: got A %b B %b expected 10/00", done_a1, done_b1); end
        tests_run++; if (done_a2 !== 2'b00 || call_after !== 2'b00 || busy_after !== 1'b0) begin tests_failed++; $display("[TB] FAIL wra_after: got done2 %b call %b busy %b expected 00/00/0", done_a2, call_after, busy_after); end
    endtask

    task automatic test_read_b();
        call_b = 2'b01; addr_b = 24'h000100; wdata_b = {$urandom, $urandom};
        exp_data_b = mem_read(24'h000100);
        run_txn(3, 1'b0, 1'b0, 1'b1);
        model_last = 1'b1;
        tests_run++; if (timed_out || seen_grant !== 1'b1 || seen_call !== 2'b01) begin tests_failed++; $display("[TB] FAIL rdb_grant: got grant %b call %b expected 1/01", seen_grant, seen_call); end
        tests_run++; if (done_b1 !== 2'b01 || done_a1 !== 2'b00 || done_b2 !== 2'b00) begin tests_failed++; $display("[TB] FAIL rdb_done: got B %b A %b B2 %b expected 01/00/00", done_b1, done_a1, done_b2); end
        tests_run++; if (data_b_after !== 64'h1122334455667788) begin tests_failed++; $display("[TB] FAIL rdb_data: got %h expected 1122334455667788", data_b_after); end
        tests_run++; if (data_a_after !== exp_data_a) begin tests_failed++; $display("[TB] FAIL rdb_data_a_kept: got %h expected %h", data_a_after, exp_data_a); end
    endtask

    task automatic test_round_robin();
        bit exp_g;
        logic [1:0] exp_op;
        logic [63:0] exp_rd;
        call_a = 2'b10; addr_a = 24'h000200; wdata_a = {$urandom, $urandom};
        call_b = 2'b01; addr_b = 24'h000200; wdata_b = {$urandom, $urandom};
        for (int k = 0; k < 4; k++) begin
            exp_g = model_pick(1'b1, 1'b1, 1'b1, model_last);
            exp_op = model_op(exp_g ? call_b : call_a);
            exp_rd = mem_read(exp_g ? addr_b : addr_a);
            run_txn($urandom_range(0, 3), 1'b0, 1'b0, 1'b0);
            model_last = exp_g;
            if (exp_op[0]) begin if (exp_g) exp_data_b = exp_rd; else exp_data_a = exp_rd; end
            tests_run++; if (timed_out || seen_grant !== exp_g) begin tests_failed++; $display("[TB] FAIL rr_grant%0d: got %b expected %b", k, seen_grant, exp_g); end
            tests_run++; if ((exp_g ? done_b1 : done_a1) !== exp_op || (exp_g ? done_a1 : done_b1) !== 2'b00) begin tests_failed++; $display("[TB] FAIL rr_done%0d: got A %b B %b op %b", k, done_a1, done_b1, exp_op); end
            tests_run++; if (data_a_after !== exp_data_a || data_b_after !== exp_data_b) begin tests_failed++; $display("[TB] FAIL rr_data%0d: got %h/%h expected %h/%h", k, data_a_after, data_b_after, exp_data_a, exp_data_b); end
            tests_run++; if (wait_cycles != 1 || low_after != 2) begin tests_failed++; $display("[TB] FAIL rr_gap%0d: got wait %0d low %0d expected 1/2", k, wait_cycles, low_after); end
        end
        call_a = 2'b00; call_b = 2'b00;
    endtask

    task automatic test_done_filter();
        call_a = 2'b10; addr_a = 24'h000300; wdata_a = {$urandom, $urandom};
        run_txn(1, 1'b1, 1'b1, 1'b1);
        model_last = 1'b0;
        tests_run++; if (timed_out || !held_ok) begin tests_failed++; $display("[TB] FAIL wrongdone_hold: got call not held (timeout %b) expected 10 held", timed_out); end
        tests_run++; if (done_a1 !== 2'b10 || done_b1 !== 2'b00) begin tests_failed++; $display("[TB] FAIL dropped_req_done: got A %b B %b expected 10/00", done_a1, done_b1); end
        i_done = 2'b11;
        @(negedge CLOCK);
        i_done = 2'b00;
        tests_run++; if ({o_done_a, o_done_b, o_call, o_busy} !== 7'b0) begin tests_failed++; $display("[TB] FAIL idle_done1: got done %b/%b call %b busy %b expected all 0", o_done_a, o_done_b, o_call, o_busy); end
        @(negedge CLOCK);
        tests_run++; if ({o_done_a, o_done_b, o_call} !== 6'b0) begin tests_failed++; $display("[TB] FAIL idle_done2: got done %b/%b call %b expected all 0", o_done_a, o_done_b, o_call); end
    endtask

    task automatic test_write_priority();
        logic [63:0] exp_rd;
        call_a = 2'b11; addr_a = 24'h000400; wdata_a = {$urandom, $urandom};
        run_txn(0, 1'b0, 1'b0, 1'b1);
        model_last = 1'b0;
        tests_run++; if (timed_out || seen_call !== 2'b10 || seen_wdata !== wdata_a) begin tests_failed++; $display("[TB] FAIL rw_both_call: got %b/%h expected 10/%h", seen_call, seen_wdata, wdata_a); end
        tests_run++; if (done_a1 !== 2'b10 || data_a_after !== exp_data_a) begin tests_failed++; $display("[TB] FAIL rw_both_done: got %b/%h expected 10/%h", done_a1, data_a_after, exp_data_a); end
        call_a = 2'b01; addr_a = 24'h000400;
        call_b = 2'b10; addr_b = 24'h000500; wdata_b = {$urandom, $urandom};
        run_txn(1, 1'b0, 1'b0, 1'b1);
        model_last = 1'b1;
        tests_run++; if (timed_out || seen_grant !== 1'b1 || low_after != 2) begin tests_failed++; $display("[TB] FAIL b2b_first: got grant %b low %0d expected 1/2", seen_grant, low_after); end
        exp_rd = mem_read(24'h000400);
        run_txn(0, 1'b0, 1'b0, 1'b1);
        model_last = 1'b0; exp_data_a = exp_rd;
        tests_run++; if (timed_out || wait_cycles != 1 || seen_grant !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_gap: got wait %0d grant %b expected 1/0", wait_cycles, seen_grant); end
        tests_run++; if (data_a_after !== exp_rd || done_a1 !== 2'b01) begin tests_failed++; $display("[TB] FAIL b2b_read: got %h/%b expected %h/01", data_a_after, done_a1, exp_rd); end
    endtask

    task automatic test_fixed_priority();
        logic [63:0] exp_rd;
        use_fp = 1'b1;
        reset_both();
        call_a = 2'b10; addr_a = 24'h000600; wdata_a = {$urandom, $urandom};
        call_b = 2'b01; addr_b = 24'h000600; wdata_b = {$urandom, $urandom};
        for (int k = 0; k < 3; k++) begin
            run_txn($urandom_range(0, 2), 1'b0, 1'b0, 1'b0);
            tests_run++; if (timed_out || seen_grant !== 1'b0 || done_a1 !== 2'b10) begin tests_failed++; $display("[TB] FAIL fp_grant%0d: got grant %b done %b expected 0/10", k, seen_grant, done_a1); end
        end
        call_a = 2'b00;
        exp_rd = mem_read(24'h000600);
        run_txn(1, 1'b0, 1'b0, 1'b1);
        tests_run++; if (timed_out || seen_grant !== 1'b1 || data_b_after !== exp_rd) begin tests_failed++; $display("[TB] FAIL fp_b_after_a: got grant %b data %h expected 1/%h", seen_grant, data_b_after, exp_rd); end
        use_fp = 1'b0;
        reset_both();
    endtask

    task automatic test_reset_mid();
        int n;
        call_a = 2'b01; addr_a = 24'h000100;
        n = 0;
        do begin @(negedge CLOCK); n++; end while (o_call == 2'b00 && n < 20);
        tests_run++; if (o_call !== 2'b01 || o_busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL rstmid_call: got %b busy %b expected 01/1", o_call, o_busy); end
        #2 RESET = 1'b0;
        #1;
        tests_run++; if ({o_call, o_busy, o_done_a, o_done_b} !== 7'b0) begin tests_failed++; $display("[TB] FAIL rstmid_async: got call %b busy %b done %b/%b expected all 0", o_call, o_busy, o_done_a, o_done_b); end
        tests_run++; if ({o_addr, o_data_a, o_data_b} !== '0) begin tests_failed++; $display("[TB] FAIL rstmid_regs: got %h/%h/%h expected 0", o_addr, o_data_a, o_data_b); end
        model_last = 1'b1; exp_data_a = '0; exp_data_b = '0;
        call_a = 2'b00;
        @(negedge CLOCK);
        RESET = 1'b1;
        call_a = 2'b10; addr_a = 24'h000700; wdata_a = {$urandom, $urandom};
        run_txn(1, 1'b0, 1'b0, 1'b1);
        model_last = 1'b0;
        tests_run++; if (timed_out || wait_cycles != 1 || seen_grant !== 1'b0 || done_a1 !== 2'b10) begin tests_failed++; $display("[TB] FAIL rstmid_recover: got wait %0d grant %b done %b expected 1/0/10", wait_cycles, seen_grant, done_a1); end
    endtask

    task automatic test_random();
        bit exp_g;
        logic [1:0] exp_op;
        logic [23:0] exp_addr;
        logic [63:0] exp_wd, exp_rd;
        for (int k = 0; k < 24; k++) begin
            if (call_a == 2'b00 && $urandom_range(0, 2) != 0) begin
                call_a = ($urandom_range(0, 2) == 0) ? 2'b01 : (($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11);
                addr_a = 24'($urandom_range(0, 7)) << 4; wdata_a = {$urandom, $urandom};
            end
            if (call_b == 2'b00 && ($urandom_range(0, 2) != 0 || call_a == 2'b00)) begin
                call_b = ($urandom_range(0, 2) == 0) ? 2'b10 : (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11);
                addr_b = 24'($urandom_range(0, 7)) << 4; wdata_b = {$urandom, $urandom};
            end
            exp_g = model_pick(call_a != 2'b00, call_b != 2'b00, 1'b1, model_last);
            exp_op = model_op(exp_g ? call_b : call_a);
            exp_addr = exp_g ? addr_b : addr_a;
            exp_wd = exp_g ? wdata_b : wdata_a;
            exp_rd = mem_read(exp_addr);
            run_txn($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
            model_last = exp_g;
            if (exp_op[0]) begin if (exp_g) exp_data_b = exp_rd; else exp_data_a = exp_rd; end
            tests_run++; if (timed_out || wait_cycles != 1 || seen_grant !== exp_g) begin tests_failed++; $display("[TB] FAIL rnd_grant%0d: got grant %b wait %0d expected %b/1", k, seen_grant, wait_cycles, exp_g); end
            tests_run++; if (seen_call !== exp_op || seen_addr !== exp_addr || (exp_op[1] && seen_wdata !== exp_wd)) begin tests_failed++; $display("[TB] FAIL rnd_cmd%0d: got %b/%h/%h expected %b/%h/%h", k, seen_call, seen_addr, seen_wdata, exp_op, exp_addr, exp_wd); end
            tests_run++; if (!held_ok) begin tests_failed++; $display("[TB] FAIL rnd_hold%0d: got unstable call expected held", k); end
            tests_run++; if ((exp_g ? done_b1 : done_a1) !== exp_op || (exp_g ? done_a1 : done_b1) !== 2'b00 || {done_a2, done_b2} !== 4'b0) begin tests_failed++; $display("[TB] FAIL rnd_done%0d: got %b/%b then %b/%b op %b", k, done_a1, done_b1, done_a2, done_b2, exp_op); end
            tests_run++; if (data_a_after !== exp_data_a || data_b_after !== exp_data_b) begin tests_failed++; $display("[TB] FAIL rnd_data%0d: got %h/%h expected %h/%h", k, data_a_after, data_b_after, exp_data_a, exp_data_b); end
            tests_run++; if (low_after != 2 || busy_after !== 1'b0) begin tests_failed++; $display("[TB] FAIL rnd_gap%0d: got low %0d busy %b expected 2/0", k, low_after, busy_after); end
        end
        call_a = 2'b00; call_b = 2'b00;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish by 1 ms expected completion");
        $fatal(1, "[TB] time limit reached");
    end

    initial begin
        use_fp = 1'b0;
        call_a = 2'b00; call_b = 2'b00; i_done = 2'b00; i_data = '0;
        addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
        test_reset();
        test_write_a();
        test_read_b();
        test_round_robin();
        test_done_filter();
        test_write_priority();
        test_fixed_priority();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sdram_arbmod.md
Name: sdram_arbmod

Overview:
- Two-port arbiter and sequencer in front of the SDRAM base module's call/done interface (2-bit call: [1]Write, [0]Read; 24-bit address; 64-bit data).
- Lets two independent masters share one SDRAM, e.g. a capture writer (port A) and a display reader (port B).
- Grants one transaction at a time: round-robin or fixed priority. Latches address and data at grant, holds the call until done, and returns done and read data to the granted port.

Parameters:
- RR_EN, 1, 1 = round-robin between A/B; 0 = fixed priority, A wins.
- AW, 24, address width.
- DW, 64, data width.

Ports:
- CLOCK  in  1  system clock, all logic on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- iCallA  in  2  port A request: [1]Write, [0]Read; held until oDoneA pulses.
- oDoneA  out  2  port A one-cycle completion pulse, same bit as the request.
- iAddrA  in  AW  port A address.
- iDataA  in  DW  port A write data.
- oDataA  out  DW  port A read data, registered.
- iCallB / oDoneB / iAddrB / iDataB / oDataB: same as port A, for port B.
- oCall  out  2  to SDRAM base module: [1]Write, [0]Read.
- iDone  in  2  from SDRAM base module: completion pulse.
- oAddr  out  AW  to SDRAM base module.
- oData  out  DW  write data to SDRAM base module.
- iData  in  DW  read data from SDRAM base module.
- oBusy  out  1  high while a transaction is granted.
- oGrant  out  1  0 = A, 1 = B; valid while oBusy.

Behaviour:
- Reset (RESET low, asynchronous): state IDLE. oCall, oDoneA, oDoneB, oAddr, oData, oDataA, oDataB, oBusy, oGrant are all 0. Round-robin pointer favours A.
- States: IDLE -> CALL -> DONE -> IDLE.
- IDLE, grant selection:
  - A port is pending if its iCall != 0.
  - One port pending: grant it.
  - Both pending with RR_EN = 1: grant the port not granted last.
  - Both pending with RR_EN = 0: grant A.
  - On grant, latch the op, iAddrX, iDataX into oAddr/oData. Set oGrant, oBusy = 1 and drive oCall = op. Go to CALL.
  - If a port drives iCall = 2'b11, the op is Write; the Read is ignored.
- Latency: request seen in IDLE at cycle t -> oCall high at t+1.
- CALL:
  - Hold oCall, oAddr, oData stable.
  - Wait for iDone with the bit matching the op. Non-matching iDone bits are ignored.
  - On the matching iDone at cycle n:
    - at n+1, oCall = 0 and oDoneX[op] pulses for exactly one cycle;
    - for a Read, iData is captured into oDataX at the same edge;
    - the round-robin pointer is updated; go to DONE.
  - A requester dropping iCall during CALL does not abort the transaction; done is still pulsed.
- DONE: one idle cycle so the requester can drop iCall. oBusy = 0. Go to IDLE.
  - Earliest next oCall is n+3, so there are at least 2 cycles of oCall low between transactions, as the base module requires.
- iDone in IDLE or DONE: ignored.
- oDataX holds its value until the next Read completion on that port. It is never overwritten by the other port's reads.
- Reset mid-transaction: returns to IDLE immediately with all outputs 0. The base module shares the same reset; no recovery sequence is needed.

Decomposition:
- Package sdram_arb_pkg:
  - state encoding IDLE/CALL/DONE;
  - op bit indices WR = 1, RD = 0;
  - default AW/DW constants.
- Sub-module sdram_rrpick: combinational 2-way round-robin picker.
  - Inputs: reqA, reqB, last, RR_EN.
  - Outputs: gnt_valid, gnt_sel.
  - Instantiated once. The FSM, latches and data capture stay in sdram_arbmod.

Test Plan:
1. A write only:
   - Stimulus: iCallA = 2'b10, iAddrA = 24'h000100, iDataA = 64'h1122334455667788.
   - Response: oCall = 2'b10 at t+1 with oAddr/oData equal to those values. After iDone = 2'b10, oDoneA = 2'b10 for one cycle; oDoneB stays 0.
2. B read:
   - Stimulus: iCallB = 2'b01, addr 24'h000100; model returns iData = 64'h1122334455667788 with iDone = 2'b01.
   - Response: oDataB = 64'h1122334455667788, oDoneB = 2'b01 pulse, oDataA unchanged.
3. Simultaneous A and B requests held continuously, RR_EN = 1:
   - Response: grants alternate A, B, A, B (oGrant 0, 1, 0, 1). With RR_EN = 0, all grants go to A while A keeps requesting.
4. iDone = 2'b01 while a Write is in CALL:
   - Response: ignored, oCall stays 2'b10.
   - Then iDone = 2'b10 -> completion. iDone pulsed in IDLE -> no oDone pulse.
5. RESET low while in CALL:
   - Response: oCall, oBusy, oDone* go to 0 immediately, before any clock edge.
   - After release, a new A request is granted normally at t+1.
6. iCallA = 2'b11:
   - Response: Write issued (oCall = 2'b10), oDoneA = 2'b10.
   - Minimum oCall-low gap between back-to-back transactions is 2 cycles.
